instr_fetch_queue: RTL and testbench
====================================

// Module: instr_fetch_queue
// PURPOSE
//  Fetch front-end of the single-cycle core. Generates sequential PCs and issues
//  requests to a pipelined instruction memory over a req/gnt + rvalid protocol.
//  Buffers returned words with their PCs in a DEPTH-entry queue. Presents them to
//  decode through a valid/ready handshake. Taken branches/jumps flush the queue via redirect.
// PARAMETERS
//  DEPTH      4       queue entries (power of 2, >=2)
//  MAX_OUTST  2       max memory requests granted but not yet returned
//  PC_RESET   32'h0   first fetch address after reset
// PORTS
//  clk_i          in   1   clock, rising edge
//  rst_i          in   1   asynchronous reset, active-low
//  redirect_i     in   1   flush queue, restart fetch at redirect_pc_i
//  redirect_pc_i  in   32  new fetch PC (word aligned)
//  imem_req_o     out  1   fetch request
//  imem_addr_o    out  32  fetch address
//  imem_gnt_i     in   1   request accepted this cycle
//  imem_rvalid_i  in   1   response valid; responses return in order
//  imem_rdata_i   in   32  instruction word
//  instr_valid_o  out  1   instr_o/instr_pc_o valid
//  instr_o        out  32  instruction to decode
//  instr_pc_o     out  32  PC of instr_o
//  instr_ready_i  in   1   decode accepts; fire = valid & ready
// BEHAVIOUR
//  - Reset (rst_i=0): state=BOOT, fetch_pc=resp_pc=PC_RESET, queue empty, outst=0.
//    All outputs 0 while reset is asserted.
//  - FSM: BOOT -> FETCH after 1 cycle. FETCH -> HOLD when credit==0. HOLD -> FETCH when credit>0.
//    Any state -> FETCH on redirect.
//  - credit = DEPTH - count - outst. Also, outst must be < MAX_OUTST.
//    imem_req_o=1 only in FETCH with credit>0.
//  - On req&gnt: fetch_pc += 4; outst++. imem_addr_o = fetch_pc.
//    The request holds stable until gnt, except on redirect.
//  - On rvalid: outst--. If discard>0, discard-- and drop the data.
//    Else push {resp_pc, rdata}; resp_pc += 4.
//  - Pop on fire. Simultaneous push and pop leave count unchanged.
//    Push never occurs when full (guaranteed by credit).
//  - Latency: req granted at cycle N, rvalid at N+k (k>=1).
//    instr_valid_o is asserted at N+k+1.
//  - Redirect (one cycle):
//    * next cycle: queue emptied; fetch_pc=resp_pc=redirect_pc_i;
//      discard=outst (minus any response arriving that same cycle).
//    * instr_valid_o forced 0 in the redirect cycle, so a fire there is impossible.
//    * a req&gnt in the redirect cycle counts as outstanding and is discarded.
//  - PC arithmetic is modulo 2^32; 32'hFFFFFFFC + 4 wraps to 0.
//  - Reset mid-operation: immediate return to reset state.
//    In-flight responses are the memory's responsibility (memory is reset too).
// CONFIGURATION
//  IFQ_BYPASS_EN defined: when the queue is empty and a non-discarded response arrives,
//    instr_valid_o=1 with rdata/resp_pc combinationally in the same cycle.
//    If instr_ready_i=1 the entry is not pushed. Latency becomes N+k.
//  IFQ_BYPASS_EN undefined: every response goes through the queue (latency N+k+1).
//    There is no combinational path from imem_* to instr_*.
// STRUCTURE
//  - Package fetch_pkg: state enum {BOOT,FETCH,HOLD}, PC_STEP=4, PC_RESET default,
//    entry struct {pc[31:0], instr[31:0]}.
//  - One sub-module: ifq_fifo, a DEPTH-entry ring buffer (wr/rd pointers with an
//    extra wrap bit, full/empty/count).
//  - Top level holds the FSM, counters and the redirect/discard logic.
// TESTING
//  1. Reset low 3 cycles, then high: req=0 in the BOOT cycle.
//     Next cycle req=1, addr=0x0. instr_valid_o=0 throughout reset.
//  2. gnt=1, rvalid 1 cycle after gnt, ready=1: instr_pc_o runs 0x0,0x4,0x8,...
//     one per cycle, data matches memory.
//  3. ready=0 for 12 cycles: count saturates at 4, req drops, no lost or duplicated words.
//     Release: 4 pops in PC order, then fetch resumes.
//  4. Redirect to 0x100 with 2 outstanding: both late responses are dropped.
//     The next valid output has instr_pc_o=0x100.
//  5. Redirect in the same cycle as ready=1 and a valid entry: no fire.
//     Following outputs start at redirect_pc. fetch_pc=0xFFFFFFFC wraps to 0x0.
//  6. IFQ_BYPASS_EN on: with the queue empty, rvalid with ready=1 gives
//     instr_valid_o=1 in the same cycle and count stays 0. Off: valid appears 1 cycle later.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch queue.
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT,
        FETCH,
        HOLD
    } fetch_state_e;

    localparam logic [31:0] PC_STEP      = 32'd4;
    localparam logic [31:0] PC_RESET_DEF = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/ifq_fifo.sv
// DEPTH-entry ring buffer of fetched {pc, instr} entries; pointers carry an extra
// wrap bit so full/empty/count fall out of a simple compare and subtract.
module ifq_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  fetch_entry_t           wdata_i,
    input  logic                   pop_i,
    output fetch_entry_t           rdata_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    fetch_entry_t r_mem [DEPTH];
    logic [AW:0]  r_wr_ptr;
    logic [AW:0]  r_rd_ptr;

    // NOTE: storage has no reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk_i) begin
        if (push_i) r_mem[r_wr_ptr[AW-1:0]] <= wdata_i;
    end

    // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (push_i) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (pop_i)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

    assign count_o = r_wr_ptr - r_rd_ptr;
    assign empty_o = (r_wr_ptr == r_rd_ptr);
    assign full_o  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign rdata_o = r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch front-end: sequential PCs, pipelined imem req/gnt/rvalid, response queue and
// redirect flush. Define IFQ_BYPASS_EN to forward a response straight to decode when the queue is empty.
module instr_fetch_queue
    import fetch_pkg::*;
#(
    parameter int          DEPTH     = 4,
    parameter int          MAX_OUTST = 2,
    parameter logic [31:0] PC_RESET  = PC_RESET_DEF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    input  logic        instr_ready_i
);
    localparam int            CW      = $clog2(DEPTH) + 1;
    localparam int            OW      = $clog2(MAX_OUTST + 1);
    localparam logic [OW-1:0] OUT_ONE = OW'(1);

    fetch_state_e r_state;
    fetch_state_e w_state_nxt;
    logic [31:0]  r_fetch_pc;
    logic [31:0]  r_resp_pc;
    logic [OW-1:0] r_outst;
    logic [OW-1:0] w_outst_nxt;
    logic [OW-1:0] r_discard;

    logic         w_req;
    logic         w_grant;
    logic         w_keep;
    logic         w_push;
    logic         w_pop;
    logic         w_fifo_empty;
    logic         w_fifo_full;
    logic [CW-1:0] w_count;
    logic [31:0]  w_used;
    logic         w_credit_pos;
    logic         w_outst_ok;
    fetch_entry_t w_head;
    fetch_entry_t w_wdata;
    fetch_entry_t w_out;

    // Credit counts both queued words and words still in flight, so a push can never overflow.
    assign w_used       = 32'(w_count) + 32'(r_outst);
    assign w_credit_pos = (w_used < 32'(DEPTH));
    assign w_outst_ok   = (32'(r_outst) < 32'(MAX_OUTST));

    always_comb begin
        // NOTE: every signal driven here gets a default first so no latch is inferred.
        w_state_nxt = r_state;
        w_req       = 1'b0;
        case (r_state)
            BOOT:  w_state_nxt = FETCH;
            FETCH: begin
                w_req = w_credit_pos && w_outst_ok;
                if (!w_credit_pos) w_state_nxt = HOLD;
            end
            HOLD:  if (w_credit_pos) w_state_nxt = FETCH;
            default: w_state_nxt = BOOT;
        endcase
        if (redirect_i) w_state_nxt = FETCH;
    end

    assign w_grant     = w_req && imem_gnt_i;
    assign imem_req_o  = w_req;
    assign imem_addr_o = (r_state == BOOT) ? '0 : r_fetch_pc;

    always_comb begin
        w_outst_nxt = r_outst;
        case ({w_grant, imem_rvalid_i})
            2'b10:   w_outst_nxt = r_outst + OUT_ONE;
            2'b01:   w_outst_nxt = r_outst - OUT_ONE;
            default: w_outst_nxt = r_outst;
        endcase
    end

    assign w_keep  = imem_rvalid_i && (r_discard == '0);
    assign w_wdata = '{pc: r_resp_pc, instr: imem_rdata_i};

`ifdef IFQ_BYPASS_EN
    logic w_bypass;
    assign w_bypass      = w_keep && w_fifo_empty && !redirect_i;
    assign instr_valid_o = (!w_fifo_empty || w_bypass) && !redirect_i;
    assign w_out         = w_fifo_empty ? w_wdata : w_head;
    assign w_push        = w_keep && !(w_bypass && instr_ready_i);
    assign w_pop         = !w_fifo_empty && instr_valid_o && instr_ready_i;
`else
    assign instr_valid_o = !w_fifo_empty && !redirect_i;
    assign w_out         = w_head;
    assign w_push        = w_keep;
    assign w_pop         = instr_valid_o && instr_ready_i;
`endif

    assign instr_o    = instr_valid_o ? w_out.instr : '0;
    assign instr_pc_o = instr_valid_o ? w_out.pc    : '0;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state    <= BOOT;
            r_fetch_pc <= PC_RESET;
            r_resp_pc  <= PC_RESET;
            r_outst    <= '0;
            r_discard  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_outst <= w_outst_nxt;
            if (redirect_i) begin
                // Everything still in flight after this edge belongs to the old stream.
                r_fetch_pc <= redirect_pc_i;
                r_resp_pc  <= redirect_pc_i;
                r_discard  <= w_outst_nxt;
            end else begin
                if (w_grant) r_fetch_pc <= r_fetch_pc + PC_STEP;
                if (w_keep)  r_resp_pc  <= r_resp_pc + PC_STEP;
                if (imem_rvalid_i && (r_discard != '0)) r_discard <= r_discard - OUT_ONE;
            end
        end
    end

    ifq_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (redirect_i),
        .push_i  (w_push && !w_fifo_full),
        .wdata_i (w_wdata),
        .pop_i   (w_pop),
        .rdata_o (w_head),
        .full_o  (w_fifo_full),
        .empty_o (w_fifo_empty),
        .count_o (w_count)
    );

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue with an in-order pipelined memory model
// (rdata = ~addr, configurable latency). Build with +define+IFQ_BYPASS_EN for the bypass variant.
`timescale 1ns/1ps
module tb_instr_fetch_queue;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i = 1'b0;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_ready_i = 1'b0;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_pc;
    logic        got;

    instr_fetch_queue #(
        .DEPTH     (4),
        .MAX_OUTST (2),
        .PC_RESET  (32'h0)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .instr_valid_o (instr_valid_o),
        .instr_o       (instr_o),
        .instr_pc_o    (instr_pc_o),
        .instr_ready_i (instr_ready_i)
    );

    always #5 clk_i = ~clk_i;

    // Memory model: grants sampled mid-cycle, responses released in order after mem_lat cycles.
    logic [31:0] mq_addr[$];
    int          mq_due[$];
    int          cyc = 0;
    int          mem_lat = 1;

    always @(negedge clk_i) begin
        if (!rst_i) begin
            mq_addr.delete();
            mq_due.delete();
        end else if (imem_req_o && imem_gnt_i) begin
            mq_addr.push_back(imem_addr_o);
            mq_due.push_back(cyc + mem_lat);
        end
    end

    initial begin
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = '0;
        forever begin
            @(posedge clk_i);
            #1;
            cyc++;
            if (rst_i && mq_addr.size() > 0 && mq_due[0] <= cyc) begin
                imem_rvalid_i = 1'b1;
                imem_rdata_i  = ~mq_addr.pop_front();
                void'(mq_due.pop_front());
            end else begin
                imem_rvalid_i = 1'b0;
                imem_rdata_i  = '0;
            end
        end
    end

    task automatic drive_edge;
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_fire(input int budget, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk_i);
            if (instr_valid_o && instr_ready_i) ok = 1'b1;
        end
    endtask

    task automatic test_reset;
        #2 rst_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            n_cmp++;
            if (imem_req_o !== 1'b0 || instr_valid_o !== 1'b0 || imem_addr_o !== 32'h0 ||
                instr_o !== 32'h0 || instr_pc_o !== 32'h0) begin
                n_err++;
                $display("FAIL reset_outputs: req=%b valid=%b addr=%h instr=%h pc=%h want all 0",
                         imem_req_o, instr_valid_o, imem_addr_o, instr_o, instr_pc_o);
            end
        end
        drive_edge();
        rst_i = 1'b1;
        @(negedge clk_i);
        n_cmp++;
        if (imem_req_o !== 1'b0) begin
            n_err++;
            $display("FAIL boot_no_req: req=%b want 0", imem_req_o);
        end
        @(negedge clk_i);
        n_cmp++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin
            n_err++;
            $display("FAIL first_req: req=%b addr=%h want req=1 addr=00000000", imem_req_o, imem_addr_o);
        end
        @(negedge clk_i);
        n_cmp++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0 || instr_valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL req_hold: req=%b addr=%h valid=%b want 1/00000000/0",
                     imem_req_o, imem_addr_o, instr_valid_o);
        end
    endtask

    task automatic test_stream;
        drive_edge();
        mem_lat       = 1;
        imem_gnt_i    = 1'b1;
        instr_ready_i = 1'b1;
        exp_pc        = 32'h0;
        wait_fire(10, got);
        n_cmp++;
        if (!got || instr_pc_o !== exp_pc || instr_o !== ~exp_pc) begin
            n_err++;
            $display("FAIL stream_first: fired=%b pc=%h instr=%h want pc=%h instr=%h",
                     got, instr_pc_o, instr_o, exp_pc, ~exp_pc);
        end
        exp_pc = exp_pc + 32'd4;
        for (int i = 1; i < 8; i++) begin
            @(negedge clk_i);
            n_cmp++;
            if (instr_valid_o !== 1'b1 || instr_pc_o !== exp_pc || instr_o !== ~exp_pc) begin
                n_err++;
                $display("FAIL stream_seq[%0d]: valid=%b pc=%h instr=%h want 1 pc=%h instr=%h",
                         i, instr_valid_o, instr_pc_o, instr_o, exp_pc, ~exp_pc);
            end
            exp_pc = exp_pc + 32'd4;
        end
    endtask

    task automatic test_backpressure;
        drive_edge();
        instr_ready_i = 1'b0;
        repeat (12) @(negedge clk_i);
        n_cmp++;
        if (imem_req_o !== 1'b0 || instr_valid_o !== 1'b1 || instr_pc_o !== exp_pc ||
            dut.u_fifo.count_o !== 3'd4) begin
            n_err++;
            $display("FAIL full_stall: req=%b valid=%b pc=%h count=%0d want 0/1/%h/4",
                     imem_req_o, instr_valid_o, instr_pc_o, dut.u_fifo.count_o, exp_pc);
        end
        drive_edge();
        instr_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            n_cmp++;
            if (instr_valid_o !== 1'b1 || instr_pc_o !== exp_pc || instr_o !== ~exp_pc) begin
                n_err++;
                $display("FAIL drain[%0d]: valid=%b pc=%h instr=%h want 1 pc=%h instr=%h",
                         i, instr_valid_o, instr_pc_o, instr_o, exp_pc, ~exp_pc);
            end
            exp_pc = exp_pc + 32'd4;
        end
        wait_fire(10, got);
        n_cmp++;
        if (!got || instr_pc_o !== exp_pc || instr_o !== ~exp_pc) begin
            n_err++;
            $display("FAIL resume: fired=%b pc=%h instr=%h want pc=%h", got, instr_pc_o, instr_o, exp_pc);
        end
    endtask

    task automatic test_redirect_discard;
        drive_edge();
        imem_gnt_i    = 1'b0;
        instr_ready_i = 1'b1;
        repeat (8) @(negedge clk_i);
        drive_edge();
        mem_lat    = 4;
        imem_gnt_i = 1'b1;
        drive_edge();
        drive_edge();
        imem_gnt_i    = 1'b0;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_0100;
        @(negedge clk_i);
        n_cmp++;
        if (dut.r_outst !== 2'd2 || instr_valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL redirect_outst: outst=%0d valid=%b want 2/0", dut.r_outst, instr_valid_o);
        end
        drive_edge();
        redirect_i = 1'b0;
        imem_gnt_i = 1'b1;
        wait_fire(20, got);
        n_cmp++;
        if (!got || instr_pc_o !== 32'h100 || instr_o !== ~32'h100) begin
            n_err++;
            $display("FAIL redirect_first: fired=%b pc=%h instr=%h want pc=00000100 instr=%h",
                     got, instr_pc_o, instr_o, ~32'h100);
        end
        wait_fire(10, got);
        n_cmp++;
        if (!got || instr_pc_o !== 32'h104 || instr_o !== ~32'h104) begin
            n_err++;
            $display("FAIL redirect_second: fired=%b pc=%h instr=%h want pc=00000104", got, instr_pc_o, instr_o);
        end
    endtask

    task automatic test_redirect_no_fire;
        logic [31:0] wrap_pc [4];
        wrap_pc[0] = 32'hFFFF_FFF8;
        wrap_pc[1] = 32'hFFFF_FFFC;
        wrap_pc[2] = 32'h0000_0000;
        wrap_pc[3] = 32'h0000_0004;
        drive_edge();
        instr_ready_i = 1'b0;
        imem_gnt_i    = 1'b1;
        mem_lat       = 1;
        repeat (6) @(negedge clk_i);
        n_cmp++;
        if (instr_valid_o !== 1'b1) begin
            n_err++;
            $display("FAIL prefill: valid=%b want 1", instr_valid_o);
        end
        drive_edge();
        instr_ready_i = 1'b1;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'hFFFF_FFF8;
        @(negedge clk_i);
        n_cmp++;
        if (instr_valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL redirect_valid: valid=%b want 0", instr_valid_o);
        end
        drive_edge();
        redirect_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wait_fire(20, got);
            n_cmp++;
            if (!got || instr_pc_o !== wrap_pc[i] || instr_o !== ~wrap_pc[i]) begin
                n_err++;
                $display("FAIL wrap[%0d]: fired=%b pc=%h instr=%h want pc=%h instr=%h",
                         i, got, instr_pc_o, instr_o, wrap_pc[i], ~wrap_pc[i]);
            end
        end
    endtask

    task automatic test_bypass;
        drive_edge();
        imem_gnt_i    = 1'b0;
        instr_ready_i = 1'b1;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_0200;
        drive_edge();
        redirect_i = 1'b0;
        repeat (8) @(negedge clk_i);
        drive_edge();
        mem_lat    = 2;
        imem_gnt_i = 1'b1;
        @(negedge clk_i);
        n_cmp++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h200) begin
            n_err++;
            $display("FAIL bypass_req: req=%b addr=%h want 1/00000200", imem_req_o, imem_addr_o);
        end
        drive_edge();
        imem_gnt_i = 1'b0;
        @(negedge clk_i);
        n_cmp++;
        if (instr_valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL bypass_idle: valid=%b want 0", instr_valid_o);
        end
        @(negedge clk_i);
`ifdef IFQ_BYPASS_EN
        n_cmp++;
        if (instr_valid_o !== 1'b1 || instr_pc_o !== 32'h200 || instr_o !== ~32'h200 ||
            dut.u_fifo.count_o !== 3'd0) begin
            n_err++;
            $display("FAIL bypass_same_cycle: valid=%b pc=%h instr=%h count=%0d want 1/00000200/%h/0",
                     instr_valid_o, instr_pc_o, instr_o, dut.u_fifo.count_o, ~32'h200);
        end
        @(negedge clk_i);
        n_cmp++;
        if (instr_valid_o !== 1'b0 || dut.u_fifo.count_o !== 3'd0) begin
            n_err++;
            $display("FAIL bypass_after: valid=%b count=%0d want 0/0", instr_valid_o, dut.u_fifo.count_o);
        end
`else
        n_cmp++;
        if (instr_valid_o !== 1'b0 || dut.u_fifo.count_o !== 3'd0) begin
            n_err++;
            $display("FAIL nobypass_same_cycle: valid=%b count=%0d want 0/0", instr_valid_o, dut.u_fifo.count_o);
        end
        @(negedge clk_i);
        n_cmp++;
        if (instr_valid_o !== 1'b1 || instr_pc_o !== 32'h200 || instr_o !== ~32'h200) begin
            n_err++;
            $display("FAIL nobypass_next: valid=%b pc=%h instr=%h want 1/00000200/%h",
                     instr_valid_o, instr_pc_o, instr_o, ~32'h200);
        end
`endif
    endtask

    task automatic test_mid_reset;
        drive_edge();
        mem_lat       = 1;
        imem_gnt_i    = 1'b1;
        instr_ready_i = 1'b0;
        repeat (4) @(negedge clk_i);
        drive_edge();
        rst_i = 1'b0;
        @(negedge clk_i);
        n_cmp++;
        if (imem_req_o !== 1'b0 || instr_valid_o !== 1'b0 || imem_addr_o !== 32'h0 ||
            instr_o !== 32'h0 || instr_pc_o !== 32'h0 || dut.u_fifo.count_o !== 3'd0) begin
            n_err++;
            $display("FAIL mid_reset: req=%b valid=%b addr=%h instr=%h pc=%h count=%0d want all 0",
                     imem_req_o, instr_valid_o, imem_addr_o, instr_o, instr_pc_o, dut.u_fifo.count_o);
        end
        drive_edge();
        rst_i = 1'b1;
        @(negedge clk_i);
        @(negedge clk_i);
        n_cmp++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin
            n_err++;
            $display("FAIL restart_req: req=%b addr=%h want 1/00000000", imem_req_o, imem_addr_o);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_discard();
        test_redirect_no_fire();
        test_bypass();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
